// File: rtl/if_stage.sv
// if_stage: MIPS instruction-fetch stage. Holds the PC, the PC+4 adder and the IF/ID latch.
// Latency: an instruction reaches IF/ID one edge after its PC is on pc_o. The first target
//   instruction reaches IF/ID two edges after a redirect is accepted.
// Backpressure: stall_i holds PC and IF/ID. start_i low freezes the PC and feeds bubbles.
// Optional: define IF_PERF_CNT_EN to build saturating stall/flush event counters.
module if_stage #(
  parameter int          IMEM_WORDS = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          CNT_W      = 32,
  localparam int         AW         = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             branch_taken_i,
  input  logic [31:0]      branch_target_i,
  input  logic             jump_i,
  input  logic [31:0]      jump_target_i,
  output logic [AW-1:0]    imem_addr_o,
  input  logic [31:0]      imem_data_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      ifid_pc4_o,
  output logic [31:0]      ifid_inst_o,
  output logic             ifid_valid_o,
  output logic             flush_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  logic [31:0] pc_plus4;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        advance;

  // Word index wraps naturally because only the low address bits are used.
  assign imem_addr_o = pc_o[AW+1:2];
  assign pc_plus4    = pc_o + 32'd4;
  assign redirect    = jump_i | branch_taken_i;
  // A jump beats a branch resolved in the same cycle. Targets are forced word-aligned.
  assign redirect_target = jump_i ? {jump_target_i[31:2], 2'b00}
                                  : {branch_target_i[31:2], 2'b00};
  // The PC moves only when running and not stalled.
  assign advance = start_i & ~stall_i;
  // A redirect seen during a stall is dropped. ID presents it again once the stall clears.
  assign flush_o = rst_i & advance & redirect;

  // PC register: a redirect target, or sequential PC+4, whenever fetch advances.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_o <= RESET_PC;
    end else if (advance) begin
      pc_o <= redirect ? redirect_target : pc_plus4;
    end
  end

  // IF/ID latch: a bubble when idle or redirecting, hold on stall, otherwise capture the fetch.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ifid_pc4_o   <= 32'd0;
      ifid_inst_o  <= 32'd0;
      ifid_valid_o <= 1'b0;
    end else if (!start_i || (!stall_i && redirect)) begin
      ifid_pc4_o   <= 32'd0;
      ifid_inst_o  <= 32'd0;
      ifid_valid_o <= 1'b0;
    end else if (!stall_i) begin
      ifid_pc4_o   <= pc_plus4;
      ifid_inst_o  <= imem_data_i;
      ifid_valid_o <= 1'b1;
    end
  end

`ifdef IF_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Saturating counters for stall cycles and accepted redirects.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (start_i && stall_i && (stall_cnt_o != CNT_MAX)) begin
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      end
      if (flush_o && (flush_cnt_o != CNT_MAX)) begin
        flush_cnt_o <= flush_cnt_o + CNT_W'(1);
      end
    end
  end
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed vectors with hand-computed expectations for if_stage.
// A bench-side instruction memory holds word i = 0x1000_0000 + i.
// The counter expectations follow the IF_PERF_CNT_EN build setting.
module tb_if_stage;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc;
  logic [31:0] ifid_pc4;
  logic [31:0] ifid_inst;
  logic        ifid_valid;
  logic        flush;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  logic [31:0] mem [0:255];
  int total;
  int bad;

  if_stage #(.IMEM_WORDS(256), .RESET_PC(32'h0), .CNT_W(32)) dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .start_i(start),
    .stall_i(stall),
    .branch_taken_i(branch_taken),
    .branch_target_i(branch_target),
    .jump_i(jump),
    .jump_target_i(jump_target),
    .imem_addr_o(imem_addr),
    .imem_data_i(imem_data),
    .pc_o(pc),
    .ifid_pc4_o(ifid_pc4),
    .ifid_inst_o(ifid_inst),
    .ifid_valid_o(ifid_valid),
    .flush_o(flush),
    .stall_cnt_o(stall_cnt),
    .flush_cnt_o(flush_cnt)
  );

  assign imem_data = mem[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 ns so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input string tag, input int exp_stall, input int exp_flush);
`ifdef IF_PERF_CNT_EN
    check({tag, "_stall_cnt"}, stall_cnt, 32'(exp_stall));
    check({tag, "_flush_cnt"}, flush_cnt, 32'(exp_flush));
`else
    check({tag, "_stall_cnt"}, stall_cnt, 32'd0);
    check({tag, "_flush_cnt"}, flush_cnt, 32'd0);
`endif
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + 32'(i);
    rst_n = 1'b0; start = 1'b1; stall = 1'b0;
    branch_taken = 1'b0; branch_target = 32'h0;
    // A redirect request during reset must not raise flush.
    jump = 1'b1; jump_target = 32'h80;
    step();
    check("rst_pc", pc, 32'h0);
    check("rst_valid", {31'b0, ifid_valid}, 32'd0);
    check("rst_inst", ifid_inst, 32'h0);
    check("rst_pc4", ifid_pc4, 32'h0);
    check("rst_flush", {31'b0, flush}, 32'd0);
    check_cnt("rst", 0, 0);
    jump = 1'b0;
    rst_n = 1'b1;

    // Sequential fetch.
    step();
    check("seq1_pc", pc, 32'h4);
    check("seq1_inst", ifid_inst, 32'h1000_0000);
    check("seq1_pc4", ifid_pc4, 32'h4);
    check("seq1_valid", {31'b0, ifid_valid}, 32'd1);
    step();
    check("seq2_pc", pc, 32'h8);
    check("seq2_inst", ifid_inst, 32'h1000_0001);
    check("seq2_pc4", ifid_pc4, 32'h8);

    // Two stall cycles at PC=8.
    stall = 1'b1;
    step();
    check("stall1_pc", pc, 32'h8);
    check("stall1_inst", ifid_inst, 32'h1000_0001);
    step();
    check("stall2_pc", pc, 32'h8);
    check("stall2_inst", ifid_inst, 32'h1000_0001);
    stall = 1'b0;
    step();
    check("post_stall_pc", pc, 32'hC);
    check("post_stall_inst", ifid_inst, 32'h1000_0002);
    check("post_stall_pc4", ifid_pc4, 32'hC);
    check_cnt("stall", 2, 0);

    // Taken branch at PC=12 to 0x40.
    branch_taken = 1'b1; branch_target = 32'h40;
    #1;
    check("br_flush", {31'b0, flush}, 32'd1);
    step();
    check("br_pc", pc, 32'h40);
    check("br_valid", {31'b0, ifid_valid}, 32'd0);
    check("br_inst", ifid_inst, 32'h0);
    branch_taken = 1'b0;
    step();
    check("br_tgt_pc", pc, 32'h44);
    check("br_tgt_inst", ifid_inst, 32'h1000_0010);
    check("br_tgt_valid", {31'b0, ifid_valid}, 32'd1);
    check_cnt("br", 2, 1);

    // Jump + branch + stall together: stall wins. Then the jump wins once the stall drops.
    jump = 1'b1; jump_target = 32'h80;
    branch_taken = 1'b1; branch_target = 32'h40;
    stall = 1'b1;
    #1;
    check("jbs_flush", {31'b0, flush}, 32'd0);
    step();
    check("jbs_pc", pc, 32'h44);
    check("jbs_inst", ifid_inst, 32'h1000_0010);
    stall = 1'b0;
    #1;
    check("jb_flush", {31'b0, flush}, 32'd1);
    step();
    check("jb_pc", pc, 32'h80);
    check("jb_valid", {31'b0, ifid_valid}, 32'd0);
    branch_taken = 1'b0;
    check_cnt("jb", 3, 2);

    // Misaligned jump target, then the address wraps past the top of memory.
    jump_target = 32'h3FE;
    step();
    check("mis_pc", pc, 32'h3FC);
    check("mis_addr", 32'(imem_addr), 32'd255);
    jump = 1'b0;
    step();
    check("wrap_pc", pc, 32'h400);
    check("wrap_addr", 32'(imem_addr), 32'd0);
    check("wrap_inst", ifid_inst, 32'h1000_00FF);
    check("wrap_pc4", ifid_pc4, 32'h400);
    check_cnt("wrap", 3, 3);

    // start low: the PC holds and a bubble enters IF/ID. Fetch then resumes at the same PC.
    start = 1'b0;
    stall = 1'b1;
    step();
    check("idle_pc", pc, 32'h400);
    check("idle_valid", {31'b0, ifid_valid}, 32'd0);
    check("idle_inst", ifid_inst, 32'h0);
    check_cnt("idle", 3, 3);
    stall = 1'b0;
    start = 1'b1;
    step();
    check("resume_pc", pc, 32'h404);
    check("resume_inst", ifid_inst, 32'h1000_0000);
    check("resume_valid", {31'b0, ifid_valid}, 32'd1);

    // Reach PC=0x20, then apply an asynchronous reset mid-cycle.
    jump = 1'b1; jump_target = 32'h20;
    step();
    jump = 1'b0;
    check("pre_rst_pc", pc, 32'h20);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_pc", pc, 32'h0);
    check("arst_valid", {31'b0, ifid_valid}, 32'd0);
    check("arst_inst", ifid_inst, 32'h0);
    check("arst_pc4", ifid_pc4, 32'h0);
    check_cnt("arst", 0, 0);
    step();
    rst_n = 1'b1;
    #1;
    check("rel_pc", pc, 32'h0);
    step();
    check("rel_step_pc", pc, 32'h4);
    check("rel_step_inst", ifid_inst, 32'h1000_0000);
    check_cnt("rel", 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined MIPS CPU. It contains the PC register and PC+4 adder, drives the instruction-memory address, and owns the IF/ID pipeline latch.
- It applies the hazard unit's stall and the ID-stage branch/jump redirects, inserting a NOP bubble on every taken redirect.
- Its outputs feed the ID stage (decoder, register file read). Its PC is the value the system bench samples as the CPU's program counter.

Parameters:
- IMEM_WORDS, 256, depth of instruction memory in 32-bit words; must be a power of two.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 32, width of the stall/flush event counters.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- start_i  input  1  run enable; low freezes fetch.
- stall_i  input  1  load-use stall from the hazard unit; holds PC and IF/ID.
- branch_taken_i  input  1  ID-stage branch resolved taken.
- branch_target_i  input  32  branch target byte address.
- jump_i  input  1  ID-stage j/jal decoded.
- jump_target_i  input  32  jump target byte address.
- imem_addr_o  output  log2(IMEM_WORDS)  word index into instruction memory.
- imem_data_i  input  32  instruction word, combinational read of imem_addr_o.
- pc_o  output  32  current PC.
- ifid_pc4_o  output  32  PC+4 of the instruction held in IF/ID.
- ifid_inst_o  output  32  instruction held in IF/ID.
- ifid_valid_o  output  1  IF/ID holds a real instruction (0 = bubble).
- flush_o  output  1  combinational; high in the cycle a redirect is accepted.
- stall_cnt_o  output  CNT_W  stall-cycle count (see Optional Feature).
- flush_cnt_o  output  CNT_W  accepted-redirect count (see Optional Feature).

Behaviour:
- Reset (rst_i low, asynchronous): pc_o=RESET_PC; ifid_pc4_o=0; ifid_inst_o=0; ifid_valid_o=0; counters=0. flush_o is 0 while in reset.
- Address and arithmetic:
  - imem_addr_o = pc_o[log2(IMEM_WORDS)+1:2]. Addresses past the memory wrap modulo IMEM_WORDS.
  - PC+4 is a 32-bit add; 32'hFFFF_FFFC wraps to 0.
  - Redirect targets have bits [1:0] forced to 0 before loading.
- Per-edge priority, highest first:
  1. start_i=0: PC holds; IF/ID loads a bubble (inst=0, valid=0, pc4=0); flush_o=0; nothing counted.
  2. stall_i=1: PC and IF/ID hold unchanged; flush_o=0; any redirect is ignored in this cycle, because ID re-presents it after the stall.
  3. jump_i=1: PC <= jump_target_i; IF/ID <= bubble; flush_o=1. Jump wins over a simultaneous branch_taken_i.
  4. branch_taken_i=1: PC <= branch_target_i; IF/ID <= bubble; flush_o=1.
  5. Otherwise: PC <= PC+4; ifid_inst_o <= imem_data_i; ifid_pc4_o <= PC+4; ifid_valid_o <= 1.
- Latency:
  - An instruction appears on ifid_inst_o one edge after its PC is on pc_o.
  - The first instruction at the target appears two edges after a redirect is accepted.
- Reset mid-operation: all state is cleared immediately. Fetch resumes from RESET_PC on the first edge after rst_i rises with start_i high.
- start_i falling mid-run: the PC is retained, so fetch resumes from the same PC when start_i returns high. No instruction is skipped or duplicated.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- Defined:
  - stall_cnt_o increments on each edge with start_i=1 and stall_i=1.
  - flush_cnt_o increments on each edge where flush_o=1.
  - Both saturate at all-ones and clear on reset.
- Undefined: both outputs are tied to 0 and no counter flops are built.

Test Plan:
- Reset, then start_i=1 with imem[0..3]=A,B,C,D and no hazards -> pc_o steps 0,4,8,12. ifid_inst_o is A at edge 2 and B at edge 3, with ifid_pc4_o=4 and 8; ifid_valid_o=1 from edge 2.
- stall_i high for 2 cycles while PC=8 -> pc_o stays 8 and IF/ID stays B for both edges. Then fetch proceeds to 12. stall_cnt_o=2 (feature on).
- branch_taken_i=1 with target 0x40 at PC=12 -> flush_o=1; next pc_o=0x40; ifid_valid_o=0 for one cycle; next instruction is imem[16]; flush_cnt_o=1.
- Same cycle: jump_i=1 (target 0x80), branch_taken_i=1 (target 0x40), stall_i=1 -> no change. Drop stall_i on the next cycle -> pc_o=0x80 (jump wins).
- jump_target_i=0x3FE (misaligned) with IMEM_WORDS=256 -> pc_o=0x3FC and imem_addr_o=255. After one more fetch, pc_o=0x400 and imem_addr_o wraps to 0.
- rst_i pulsed low asynchronously mid-cycle at PC=0x20 -> all outputs return to reset values immediately, without waiting for a clock edge. After release, pc_o=0 and the counters are 0.
